// File: rtl/icb_arbt_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icb_arbt_rr_pkg
// Brief    : Shared grant-scheme constants and a clog2 helper for the ICB arbiter
// Revision : 1.0
// ============================================================================
package icb_arbt_rr_pkg;

    localparam int ARBT_PRIO = 0;
    localparam int ARBT_RR   = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_simple.sv
`default_nettype none
// ============================================================================
// Module   : fifo_simple
// Brief    : Small synchronous FIFO with optional cut-ready input side
// Revision : 1.0
// ============================================================================
module fifo_simple
    import icb_arbt_rr_pkg::*;
#(
    parameter int CUT_READY         = 1,
    parameter int ZEROOUT_WHENEMPTY = 0,
    parameter int DP                = 1,
    parameter int DW                = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
);

    localparam int PTR_W = (DP > 1) ? clog2(DP) : 1;
    localparam int CNT_W = clog2(DP + 1);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DP - 1);
    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DP);

    logic [DW-1:0]    mem_q [DP];
    logic [DW-1:0]    mem_d [DP];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Cut-ready keeps i_rdy a pure flop output: a full FIFO never accepts,
    // even if a pop happens in the same cycle.
    always_comb begin
        w_full  = (cnt_q == C_CNT_FULL);
        w_empty = (cnt_q == '0);
        i_rdy   = (CUT_READY != 0) ? ~w_full : (~w_full | o_rdy);
        o_vld   = ~w_empty;
        w_push  = i_vld & i_rdy;
        w_pop   = o_vld & o_rdy;
        o_dat   = ((ZEROOUT_WHENEMPTY != 0) && w_empty) ? '0 : mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = i_dat;
            wr_ptr_d        = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/icb_arbt_rr_gnt.sv
`default_nettype none
// ============================================================================
// Module   : icb_arbt_rr_gnt
// Brief    : Combinational one-hot grant, fixed priority or round-robin
// Revision : 1.0
// ============================================================================
module icb_arbt_rr_gnt
    import icb_arbt_rr_pkg::*;
#(
    parameter int ARBT_NUM    = 4,
    parameter int ARBT_SCHEME = 0
) (
    input  logic [ARBT_NUM-1:0] i_req,
    input  logic [ARBT_NUM-1:0] i_rr_last,
    output logic [ARBT_NUM-1:0] o_gnt
);

    logic [ARBT_NUM-1:0] w_prio;
    logic [ARBT_NUM-1:0] w_above;
    logic [ARBT_NUM-1:0] w_req_hi;
    logic [ARBT_NUM-1:0] w_rr;

    // x & -x isolates the lowest set bit; the round-robin search first looks
    // strictly above the last winner and wraps to the lowest request otherwise.
    always_comb begin
        w_prio   = i_req & (~i_req + ARBT_NUM'(1));
        w_above  = ~(i_rr_last | (i_rr_last - ARBT_NUM'(1)));
        w_req_hi = i_req & w_above;
        w_rr     = (|w_req_hi) ? (w_req_hi & (~w_req_hi + ARBT_NUM'(1))) : w_prio;
        o_gnt    = (ARBT_SCHEME == ARBT_PRIO) ? w_prio : w_rr;
    end

endmodule
`default_nettype wire

// File: rtl/icb_arbt_rr.sv
`default_nettype none
// ============================================================================
// Module   : icb_arbt_rr
// Brief    : N:1 ICB arbiter with grant lock and in-order response routing
// Revision : 1.0
// ============================================================================
module icb_arbt_rr
    import icb_arbt_rr_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 64,
    parameter int USR_W           = 1,
    parameter int ARBT_NUM        = 4,
    parameter int ARBT_SCHEME     = 0,
    parameter int FIFO_DP         = 1,
    parameter int ALLOW_0CYCL_RSP = 1
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [ARBT_NUM-1:0]         i_bus_icb_cmd_vld,
    output logic [ARBT_NUM-1:0]         i_bus_icb_cmd_rdy,
    input  logic [ARBT_NUM-1:0]         i_bus_icb_cmd_read,
    input  logic [ARBT_NUM*AW-1:0]      i_bus_icb_cmd_addr,
    input  logic [ARBT_NUM*DW-1:0]      i_bus_icb_cmd_wdata,
    input  logic [ARBT_NUM*DW/8-1:0]    i_bus_icb_cmd_wmask,
    input  logic [ARBT_NUM*USR_W-1:0]   i_bus_icb_cmd_usr,

    output logic [ARBT_NUM-1:0]         i_bus_icb_rsp_vld,
    input  logic [ARBT_NUM-1:0]         i_bus_icb_rsp_rdy,
    output logic [ARBT_NUM-1:0]         i_bus_icb_rsp_err,
    output logic [ARBT_NUM*DW-1:0]      i_bus_icb_rsp_rdata,
    output logic [ARBT_NUM*USR_W-1:0]   i_bus_icb_rsp_usr,

    output logic                        o_icb_cmd_vld,
    input  logic                        o_icb_cmd_rdy,
    output logic                        o_icb_cmd_read,
    output logic [AW-1:0]               o_icb_cmd_addr,
    output logic [DW-1:0]               o_icb_cmd_wdata,
    output logic [DW/8-1:0]             o_icb_cmd_wmask,
    output logic [USR_W-1:0]            o_icb_cmd_usr,

    input  logic                        o_icb_rsp_vld,
    output logic                        o_icb_rsp_rdy,
    input  logic                        o_icb_rsp_err,
    input  logic [DW-1:0]               o_icb_rsp_rdata,
    input  logic [USR_W-1:0]            o_icb_rsp_usr
);

    localparam int MW = DW / 8;

    // Response fields are broadcast; only rsp_vld selects the destination.
    assign i_bus_icb_rsp_err   = {ARBT_NUM{o_icb_rsp_err}};
    assign i_bus_icb_rsp_rdata = {ARBT_NUM{o_icb_rsp_rdata}};
    assign i_bus_icb_rsp_usr   = {ARBT_NUM{o_icb_rsp_usr}};

    generate
        if (ARBT_NUM == 1) begin : g_wire
            assign o_icb_cmd_vld     = i_bus_icb_cmd_vld & ~rst;
            assign i_bus_icb_cmd_rdy = o_icb_cmd_rdy & ~rst;
            assign o_icb_cmd_read    = i_bus_icb_cmd_read;
            assign o_icb_cmd_addr    = i_bus_icb_cmd_addr;
            assign o_icb_cmd_wdata   = i_bus_icb_cmd_wdata;
            assign o_icb_cmd_wmask   = i_bus_icb_cmd_wmask;
            assign o_icb_cmd_usr     = i_bus_icb_cmd_usr;
            assign i_bus_icb_rsp_vld = o_icb_rsp_vld & ~rst;
            assign o_icb_rsp_rdy     = i_bus_icb_rsp_rdy & ~rst;
        end else begin : g_arb
            logic [ARBT_NUM-1:0] rr_last_q, rr_last_d;
            logic                lock_vld_q, lock_vld_d;
            logic [ARBT_NUM-1:0] lock_sel_q, lock_sel_d;
            logic [ARBT_NUM-1:0] w_arb_gnt;
            logic [ARBT_NUM-1:0] w_gnt;
            logic [ARBT_NUM-1:0] w_rsp_sel;
            logic [ARBT_NUM-1:0] w_fifo_head;
            logic                w_fifo_unfull;
            logic                w_fifo_nempty;
            logic                w_rsp_en;
            logic                w_cmd_hsk;
            logic                w_rsp_hsk;
            logic                w_bypass;
            logic                w_fifo_push;
            logic                w_fifo_pop;

            icb_arbt_rr_gnt #(
                .ARBT_NUM    (ARBT_NUM),
                .ARBT_SCHEME (ARBT_SCHEME)
            ) u_gnt (
                .i_req     (i_bus_icb_cmd_vld),
                .i_rr_last (rr_last_q),
                .o_gnt     (w_arb_gnt)
            );

            always_comb begin
                w_gnt             = lock_vld_q ? lock_sel_q : w_arb_gnt;
                o_icb_cmd_vld     = (|w_gnt) & w_fifo_unfull & ~rst;
                i_bus_icb_cmd_rdy = {ARBT_NUM{o_icb_cmd_rdy & w_fifo_unfull & ~rst}} & w_gnt;
            end

            always_comb begin
                o_icb_cmd_read  = 1'b0;
                o_icb_cmd_addr  = '0;
                o_icb_cmd_wdata = '0;
                o_icb_cmd_wmask = '0;
                o_icb_cmd_usr   = '0;
                for (int i = 0; i < ARBT_NUM; i++) begin
                    o_icb_cmd_read  = o_icb_cmd_read | (i_bus_icb_cmd_read[i] & w_gnt[i]);
                    o_icb_cmd_addr  = o_icb_cmd_addr  | (i_bus_icb_cmd_addr[i*AW +: AW] & {AW{w_gnt[i]}});
                    o_icb_cmd_wdata = o_icb_cmd_wdata | (i_bus_icb_cmd_wdata[i*DW +: DW] & {DW{w_gnt[i]}});
                    o_icb_cmd_wmask = o_icb_cmd_wmask | (i_bus_icb_cmd_wmask[i*MW +: MW] & {MW{w_gnt[i]}});
                    o_icb_cmd_usr   = o_icb_cmd_usr   | (i_bus_icb_cmd_usr[i*USR_W +: USR_W] & {USR_W{w_gnt[i]}});
                end
            end

            // An empty FIFO means the response can only belong to the command
            // being handshaken right now, hence the steer to the live grant.
            always_comb begin
                if (w_fifo_nempty) begin
                    w_rsp_sel = w_fifo_head;
                end else if (ALLOW_0CYCL_RSP != 0) begin
                    w_rsp_sel = w_gnt;
                end else begin
                    w_rsp_sel = '0;
                end
                w_rsp_en          = ~rst & ((ALLOW_0CYCL_RSP != 0) | w_fifo_nempty);
                i_bus_icb_rsp_vld = {ARBT_NUM{o_icb_rsp_vld & w_rsp_en}} & w_rsp_sel;
                o_icb_rsp_rdy     = w_rsp_en & (|(i_bus_icb_rsp_rdy & w_rsp_sel));
            end

            always_comb begin
                w_cmd_hsk   = o_icb_cmd_vld & o_icb_cmd_rdy;
                w_rsp_hsk   = o_icb_rsp_vld & o_icb_rsp_rdy;
                w_bypass    = (ALLOW_0CYCL_RSP != 0) & ~w_fifo_nempty & w_cmd_hsk & w_rsp_hsk;
                w_fifo_push = w_cmd_hsk & ~w_bypass;
                w_fifo_pop  = w_rsp_hsk & w_fifo_nempty;
            end

            always_comb begin
                rr_last_d  = w_cmd_hsk ? w_gnt : rr_last_q;
                lock_vld_d = lock_vld_q;
                lock_sel_d = lock_sel_q;
                if (w_cmd_hsk) begin
                    lock_vld_d = 1'b0;
                end else if (o_icb_cmd_vld & ~o_icb_cmd_rdy) begin
                    lock_vld_d = 1'b1;
                    lock_sel_d = w_gnt;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_last_q  <= {1'b1, {(ARBT_NUM-1){1'b0}}};
                    lock_vld_q <= 1'b0;
                    lock_sel_q <= '0;
                end else begin
                    rr_last_q  <= rr_last_d;
                    lock_vld_q <= lock_vld_d;
                    lock_sel_q <= lock_sel_d;
                end
            end

            fifo_simple #(
                .CUT_READY         (1),
                .ZEROOUT_WHENEMPTY (0),
                .DP                (FIFO_DP),
                .DW                (ARBT_NUM)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .i_vld (w_fifo_push),
                .i_rdy (w_fifo_unfull),
                .i_dat (w_gnt),
                .o_vld (w_fifo_nempty),
                .o_rdy (w_fifo_pop),
                .o_dat (w_fifo_head)
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_icb_arbt_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_icb_arbt_rr
// Brief    : Random lockstep bench for two arbiter configurations vs a queue model
// Revision : 1.0
// ============================================================================
module tb_icb_arbt_rr;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int UW = 1;
    localparam int MW = DW / 8;
    localparam int NCYC = 1200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    cmd_vld, cmd_read, rsp_rdy;
    logic [N*AW-1:0] cmd_addr;
    logic [N*DW-1:0] cmd_wdata;
    logic [N*MW-1:0] cmd_wmask;
    logic [N*UW-1:0] cmd_usr;
    logic            ds_cmd_rdy, ds_rsp_vld, ds_rsp_err;
    logic [DW-1:0]   ds_rsp_rdata;
    logic [UW-1:0]   ds_rsp_usr;

    logic [N-1:0]    a_cmd_rdy   [2];
    logic [N-1:0]    a_rsp_vld   [2];
    logic [N-1:0]    a_rsp_err   [2];
    logic [N*DW-1:0] a_rsp_rdata [2];
    logic [N*UW-1:0] a_rsp_usr   [2];
    logic            a_cmd_vld   [2];
    logic            a_cmd_read  [2];
    logic [AW-1:0]   a_cmd_addr  [2];
    logic [DW-1:0]   a_cmd_wdata [2];
    logic [MW-1:0]   a_cmd_wmask [2];
    logic [UW-1:0]   a_cmd_usr   [2];
    logic            a_rsp_rdy   [2];

    // Instance 0: fixed priority, depth 2, no 0-cycle response
    icb_arbt_rr #(.AW(AW), .DW(DW), .USR_W(UW), .ARBT_NUM(N), .ARBT_SCHEME(0),
                  .FIFO_DP(2), .ALLOW_0CYCL_RSP(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_bus_icb_cmd_vld(cmd_vld), .i_bus_icb_cmd_rdy(a_cmd_rdy[0]),
        .i_bus_icb_cmd_read(cmd_read), .i_bus_icb_cmd_addr(cmd_addr),
        .i_bus_icb_cmd_wdata(cmd_wdata), .i_bus_icb_cmd_wmask(cmd_wmask),
        .i_bus_icb_cmd_usr(cmd_usr),
        .i_bus_icb_rsp_vld(a_rsp_vld[0]), .i_bus_icb_rsp_rdy(rsp_rdy),
        .i_bus_icb_rsp_err(a_rsp_err[0]), .i_bus_icb_rsp_rdata(a_rsp_rdata[0]),
        .i_bus_icb_rsp_usr(a_rsp_usr[0]),
        .o_icb_cmd_vld(a_cmd_vld[0]), .o_icb_cmd_rdy(ds_cmd_rdy),
        .o_icb_cmd_read(a_cmd_read[0]), .o_icb_cmd_addr(a_cmd_addr[0]),
        .o_icb_cmd_wdata(a_cmd_wdata[0]), .o_icb_cmd_wmask(a_cmd_wmask[0]),
        .o_icb_cmd_usr(a_cmd_usr[0]),
        .o_icb_rsp_vld(ds_rsp_vld), .o_icb_rsp_rdy(a_rsp_rdy[0]),
        .o_icb_rsp_err(ds_rsp_err), .o_icb_rsp_rdata(ds_rsp_rdata),
        .o_icb_rsp_usr(ds_rsp_usr)
    );

    // Instance 1: round-robin, depth 4, 0-cycle response allowed
    icb_arbt_rr #(.AW(AW), .DW(DW), .USR_W(UW), .ARBT_NUM(N), .ARBT_SCHEME(1),
                  .FIFO_DP(4), .ALLOW_0CYCL_RSP(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_bus_icb_cmd_vld(cmd_vld), .i_bus_icb_cmd_rdy(a_cmd_rdy[1]),
        .i_bus_icb_cmd_read(cmd_read), .i_bus_icb_cmd_addr(cmd_addr),
        .i_bus_icb_cmd_wdata(cmd_wdata), .i_bus_icb_cmd_wmask(cmd_wmask),
        .i_bus_icb_cmd_usr(cmd_usr),
        .i_bus_icb_rsp_vld(a_rsp_vld[1]), .i_bus_icb_rsp_rdy(rsp_rdy),
        .i_bus_icb_rsp_err(a_rsp_err[1]), .i_bus_icb_rsp_rdata(a_rsp_rdata[1]),
        .i_bus_icb_rsp_usr(a_rsp_usr[1]),
        .o_icb_cmd_vld(a_cmd_vld[1]), .o_icb_cmd_rdy(ds_cmd_rdy),
        .o_icb_cmd_read(a_cmd_read[1]), .o_icb_cmd_addr(a_cmd_addr[1]),
        .o_icb_cmd_wdata(a_cmd_wdata[1]), .o_icb_cmd_wmask(a_cmd_wmask[1]),
        .o_icb_cmd_usr(a_cmd_usr[1]),
        .o_icb_rsp_vld(ds_rsp_vld), .o_icb_rsp_rdy(a_rsp_rdy[1]),
        .o_icb_rsp_err(ds_rsp_err), .o_icb_rsp_rdata(ds_rsp_rdata),
        .o_icb_rsp_usr(ds_rsp_usr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: last winner as an index, lock as an index, outstanding
    // transactions as a queue of port numbers.
    int  m_last   [2];
    bit  m_lock   [2];
    int  m_lock_p [2];
    int  q0 [$];
    int  q1 [$];

    function automatic int scheme_of(input int k); return k; endfunction
    function automatic int dp_of(input int k);     return (k == 0) ? 2 : 4; endfunction
    function automatic bit allow_of(input int k);  return (k == 1); endfunction
    function automatic int qsize(input int k);     return (k == 0) ? q0.size() : q1.size(); endfunction
    function automatic int qhead(input int k);     return (k == 0) ? q0[0] : q1[0]; endfunction

    task automatic qpush(input int k, input int p);
        if (k == 0) q0.push_back(p); else q1.push_back(p);
    endtask
    task automatic qpop(input int k);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask
    task automatic qclear(input int k);
        if (k == 0) q0.delete(); else q1.delete();
    endtask

    function automatic int grant_of(input int k);
        if (m_lock[k]) return m_lock_p[k];
        if (scheme_of(k) == 0) begin
            for (int i = 0; i < N; i++) if (cmd_vld[i]) return i;
        end else begin
            for (int off = 1; off <= N; off++) begin
                int p;
                p = (m_last[k] + off) % N;
                if (cmd_vld[p]) return p;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = N - 1;
            m_lock[k] = 1'b0;
            m_lock_p[k] = 0;
            qclear(k);
        end
    endtask

    task automatic check_inst(input int k, input int cyc);
        int gp, rp, sp;
        bit unfull, evld, erdy_o, chs, rhs;
        logic [N-1:0] e_crdy, e_rvld;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [MW-1:0] e_wmask;
        bit e_read;
        logic [UW-1:0] e_usr;

        gp     = grant_of(k);
        unfull = qsize(k) < dp_of(k);
        evld   = !rst && gp >= 0 && unfull;
        e_crdy = '0;
        if (!rst && ds_cmd_rdy && unfull && gp >= 0) e_crdy[gp] = 1'b1;
        e_addr = '0; e_wdata = '0; e_wmask = '0; e_read = 1'b0; e_usr = '0;
        if (gp >= 0) begin
            e_addr  = cmd_addr[gp*AW +: AW];
            e_wdata = cmd_wdata[gp*DW +: DW];
            e_wmask = cmd_wmask[gp*MW +: MW];
            e_read  = cmd_read[gp];
            e_usr   = cmd_usr[gp*UW +: UW];
        end
        if (qsize(k) > 0)   rp = qhead(k);
        else if (allow_of(k)) rp = gp;
        else                rp = -1;
        e_rvld = '0;
        if (!rst && ds_rsp_vld && rp >= 0) e_rvld[rp] = 1'b1;
        erdy_o = !rst && rp >= 0 && rsp_rdy[rp];
        sp     = cyc % N;

        chk($sformatf("u%0d.cmd_vld", k),   64'(a_cmd_vld[k]),   64'(evld));
        chk($sformatf("u%0d.cmd_rdy", k),   64'(a_cmd_rdy[k]),   64'(e_crdy));
        chk($sformatf("u%0d.cmd_addr", k),  64'(a_cmd_addr[k]),  64'(e_addr));
        chk($sformatf("u%0d.cmd_wdata", k), 64'(a_cmd_wdata[k]), 64'(e_wdata));
        chk($sformatf("u%0d.cmd_wmask", k), 64'(a_cmd_wmask[k]), 64'(e_wmask));
        chk($sformatf("u%0d.cmd_read", k),  64'(a_cmd_read[k]),  64'(e_read));
        chk($sformatf("u%0d.cmd_usr", k),   64'(a_cmd_usr[k]),   64'(e_usr));
        chk($sformatf("u%0d.rsp_vld", k),   64'(a_rsp_vld[k]),   64'(e_rvld));
        chk($sformatf("u%0d.rsp_rdy", k),   64'(a_rsp_rdy[k]),   64'(erdy_o));
        chk($sformatf("u%0d.rsp_rdata", k), 64'(a_rsp_rdata[k][sp*DW +: DW]), 64'(ds_rsp_rdata));
        chk($sformatf("u%0d.rsp_err", k),   64'(a_rsp_err[k]),   64'({N{ds_rsp_err}}));

        if (rst) begin
            m_last[k] = N - 1;
            m_lock[k] = 1'b0;
            qclear(k);
        end else begin
            chs = evld && ds_cmd_rdy;
            rhs = ds_rsp_vld && erdy_o;
            if (chs) m_last[k] = gp;
            if (chs) m_lock[k] = 1'b0;
            else if (evld) begin
                m_lock[k]   = 1'b1;
                m_lock_p[k] = gp;
            end
            if (!(qsize(k) == 0 && chs && rhs && allow_of(k))) begin
                if (rhs && qsize(k) > 0) qpop(k);
                if (chs) qpush(k, gp);
            end
        end
    endtask

    task automatic drive_random(input int cyc);
        int ph;
        ph = (cyc / 150) % 4;
        for (int i = 0; i < N; i++) begin
            cmd_addr[i*AW +: AW]  = $urandom;
            cmd_wdata[i*DW +: DW] = {$urandom, $urandom};
            cmd_wmask[i*MW +: MW] = MW'($urandom);
            cmd_usr[i*UW +: UW]   = UW'($urandom);
        end
        cmd_read     = N'($urandom);
        ds_rsp_err   = 1'($urandom);
        ds_rsp_rdata = {$urandom, $urandom};
        ds_rsp_usr   = UW'($urandom);
        case (ph)
            0: begin
                cmd_vld    = N'($urandom);
                ds_cmd_rdy = 1'($urandom);
                ds_rsp_vld = 1'($urandom);
                rsp_rdy    = N'($urandom);
            end
            1: begin
                cmd_vld    = N'($urandom);
                ds_cmd_rdy = ($urandom_range(0, 3) != 0);
                ds_rsp_vld = ($urandom_range(0, 7) == 0);
                rsp_rdy    = '1;
            end
            2: begin
                cmd_vld    = N'($urandom);
                ds_cmd_rdy = ($urandom_range(0, 5) == 0);
                ds_rsp_vld = 1'($urandom);
                rsp_rdy    = N'($urandom);
            end
            default: begin
                cmd_vld    = '1;
                ds_cmd_rdy = 1'b1;
                ds_rsp_vld = 1'b1;
                rsp_rdy    = '1;
            end
        endcase
        rst = (cyc < 2) || ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_vld = '0; cmd_read = '0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wmask = '0; cmd_usr = '0; rsp_rdy = '0;
        ds_cmd_rdy = 1'b0; ds_rsp_vld = 1'b0; ds_rsp_err = 1'b0;
        ds_rsp_rdata = '0; ds_rsp_usr = '0;
        repeat (2) @(posedge clk);
        model_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            drive_random(cyc);
            #1;
            check_inst(0, cyc);
            check_inst(1, cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icb_arbt_rr.md
# icb_arbt_rr

N:1 ICB command/response arbiter with selectable fixed-priority or round-robin grant. It bounds outstanding transactions with a routing FIFO and returns in-order responses to the requesting port. It holds a grant while the downstream stalls, so a presented command never changes before its handshake. It sits between several ICB masters and one shared ICB slave port, and succeeds the fixed-priority arbiter in the bus utilities.

## Interface
Parameters:
- AW, 32, address width
- DW, 64, data width; wmask width DW/8
- USR_W, 1, user sideband width
- ARBT_NUM, 4, number of input ports, 1..16
- ARBT_SCHEME, 0, grant scheme: 0 fixed priority (port 0 highest), 1 round-robin
- FIFO_DP, 1, max outstanding transactions, 1..16
- ALLOW_0CYCL_RSP, 1, accept a response in the same cycle as its command

Ports:
- clk  in  1  clock, single domain
- rst  in  1  reset, synchronous, active-high
- i_bus_icb_cmd_vld / _rdy  in/out  ARBT_NUM  per-port command handshake
- i_bus_icb_cmd_read  in  ARBT_NUM  per-port read flag
- i_bus_icb_cmd_addr  in  ARBT_NUM*AW  packed addresses, port i at [i*AW +: AW]
- i_bus_icb_cmd_wdata  in  ARBT_NUM*DW  packed write data
- i_bus_icb_cmd_wmask  in  ARBT_NUM*DW/8  packed byte masks
- i_bus_icb_cmd_usr  in  ARBT_NUM*USR_W  packed user bits
- i_bus_icb_rsp_vld / _rdy  out/in  ARBT_NUM  per-port response handshake
- i_bus_icb_rsp_err, _rdata, _usr  out  ARBT_NUM, ARBT_NUM*DW, ARBT_NUM*USR_W  response fields, broadcast to all ports
- o_icb_cmd_vld / _rdy  out/in  1  downstream command handshake
- o_icb_cmd_read, _addr, _wdata, _wmask, _usr  out  1, AW, DW, DW/8, USR_W  selected command fields
- o_icb_rsp_vld / _rdy  in/out  1  downstream response handshake
- o_icb_rsp_err, _rdata, _usr  in  1, DW, USR_W  downstream response fields

## Operation
- Grant is one-hot `gnt` over the valid ports.
- Scheme 0: lowest-index valid port wins.
- Scheme 1: the search starts at the port after `rr_last` (one-hot register) and wraps modulo ARBT_NUM.
- `rr_last` updates to `gnt` only on a downstream command handshake. Its reset value is bit ARBT_NUM-1, so port 0 wins first.
- Grant lock: when o_icb_cmd_vld=1 and o_icb_cmd_rdy=0, the arbiter sets `lock_vld` and stores `lock_sel`=gnt. While locked, gnt=lock_sel regardless of other requests. The lock clears on handshake.
- Command path: o_icb_cmd_vld = |gnt & fifo_unfull & ~rst. i_bus_icb_cmd_rdy[i] = o_icb_cmd_rdy & fifo_unfull & gnt[i]. Field muxes are AND-OR on gnt and output zero when gnt=0.
- Routing FIFO (depth FIFO_DP, width ARBT_NUM):
  - It pushes gnt on each command handshake.
  - It pops on each response handshake.
  - Responses are strictly in order.
- Response steering: rsp_sel = FIFO head when the FIFO is non-empty.
  - When the FIFO is empty and ALLOW_0CYCL_RSP=1, rsp_sel = current gnt.
  - When the FIFO is empty and ALLOW_0CYCL_RSP=0, rsp_sel = 0.
- Response handshake signals:
  - i_bus_icb_rsp_vld[i] = o_icb_rsp_vld & rsp_sel[i].
  - o_icb_rsp_rdy = |(i_bus_icb_rsp_rdy & rsp_sel).
  - With ALLOW_0CYCL_RSP=0, both signals are additionally gated by FIFO non-empty.
- Bypass: with the FIFO empty and command and response handshakes in the same cycle (ALLOW_0CYCL_RSP=1), neither push nor pop occurs.
- ARBT_NUM=1: direct wire-through; no FIFO, no registers.

## Timing
- Command and response paths are zero-latency combinational. Only `rr_last`, the lock and the FIFO are registered.
- Reset values:
  - rr_last = {1'b1, 0...}.
  - lock_vld = 0.
  - FIFO empty.
  - While rst=1: o_icb_cmd_vld=0, all i_bus_icb_cmd_rdy=0, o_icb_rsp_rdy=0, all i_bus_icb_rsp_vld=0.
- Reset mid-transaction drops all outstanding entries. Responses arriving after reset are not routed; with the FIFO empty they are steered as 0-cycle responses only if ALLOW_0CYCL_RSP=1.
- FIFO full (FIFO_DP outstanding) forces o_icb_cmd_vld=0. A push and a pop in the same cycle when full is not allowed; the FIFO cut-ready mode blocks it, so full stays registered.
- FIFO empty with o_icb_rsp_vld=1 and ALLOW_0CYCL_RSP=0: o_icb_rsp_rdy=0 (the response is stalled, never dropped).
- A simultaneous push and pop while the FIFO is not empty keeps the count unchanged.
- A locked grant survives any number of stall cycles and any deassertion attempts by other ports.

## Structure
- The shared include mydefines.v holds constants ARBT_PRIO=0 and ARBT_RR=1.
- The include also holds a clog2 function used for FIFO pointer widths.
- Routing FIFO: instantiate the existing fifo_simple (CUT_READY=1, ZEROOUT_WHENEMPTY=0, DP=FIFO_DP, DW=ARBT_NUM).
- One new sub-module, arbt_rr_gnt: combinational round-robin/priority grant from request vector plus rr_last, selected by ARBT_SCHEME.

## Test plan
- Scheme 0, ARBT_NUM=4, ports 1 and 3 valid, cmd_rdy=1 -> port 1 granted every cycle, port 3 starved.
- Scheme 1, all 4 ports valid continuously, FIFO_DP=4, rsp returns each cycle -> grant order 0,1,2,3,0,1.
- Port 2 presents cmd while cmd_rdy=0 for 5 cycles, port 0 raises vld at cycle 2 -> o_icb_cmd_addr stays port 2's for all 5 cycles. Port 2 handshakes first and port 0 follows.
- FIFO_DP=2, responses withheld -> after 2 handshakes o_icb_cmd_vld=0. The first response goes to the first grantee, and cmd_vld reasserts the next cycle.
- ALLOW_0CYCL_RSP=1, FIFO empty, rsp_vld in the same cycle as the port 1 handshake -> i_bus_icb_rsp_vld[1]=1 that cycle and the FIFO stays empty.
- rst asserted with 2 outstanding -> the next cycle FIFO is empty, rr_last=bit 3, and all outputs are at their reset values.
